// File: rtl/mpu_ctrl_seq.sv
// mpu_ctrl_seq
//   Parametrised MPU control sequencer. Decodes host instructions into BRAM bank
//   enables/clears, operand/result mux selects and host byte offsets for the
//   NUM_BANKS bank / ALU datapath.
//
//   Optional feature macro: MPU_CTRL_ABORT_EN (adds input 'abort').
//
//   Ports
//     clk, reset          clock, synchronous active-high reset
//     instr               {dst[SEL_W], src[SEL_W], op[3:0]}
//     instr_valid/ready   instruction handshake (ready only in IDLE)
//     host_valid          LOAD byte available
//     host_ready          UNLOAD byte consumed
//     src_sel, dst_sel    latched operand / destination bank selects
//     out_sel             ALU result select (0 ADD, 1 SHIFT, 2 SUB, 3 MULT)
//     bram_in_sel         bank-to-bank copy path
//     wr_en, wr_en1       one-hot full-word / byte write
//     bank_rst            bank clear
//     offset              MSB bit index of current byte
//     busy, done, err     status; done/err are single-cycle pulses
//     abort               (MPU_CTRL_ABORT_EN only) abandon current op
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   S_RST_ALL   | post-reset, clears every bank for one cycle
//   S_IDLE      | waiting for an instruction, instr_ready high
//   S_EXEC      | single cycle in which the op's final action is visible
//   S_MULT_WAIT | multiplier latency, result select held, no write
//   S_LOAD      | host -> bank byte stepping, gated by host_valid
//   S_UNLOAD    | bank -> host byte stepping, gated by host_ready
module mpu_ctrl_seq #(
  parameter int NUM_BANKS   = 4,
  parameter int DATA_BITS   = 512,
  parameter int BYTE_BITS   = 8,
  parameter int MULT_CYCLES = 4,
  localparam int SEL_W      = $clog2(NUM_BANKS),
  localparam int INSTR_W    = 2 * SEL_W + 4,
  localparam int OFF_W      = $clog2(DATA_BITS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 host_valid,
  input  logic                 host_ready,
`ifdef MPU_CTRL_ABORT_EN
  input  logic                 abort,
`endif
  output logic [SEL_W-1:0]     src_sel,
  output logic [SEL_W-1:0]     dst_sel,
  output logic [1:0]           out_sel,
  output logic                 bram_in_sel,
  output logic [NUM_BANKS-1:0] wr_en,
  output logic [NUM_BANKS-1:0] wr_en1,
  output logic [NUM_BANKS-1:0] bank_rst,
  output logic [OFF_W-1:0]     offset,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int NBYTES = DATA_BITS / BYTE_BITS;
  localparam int CNT_W  = $clog2(NBYTES);
  localparam int MC_W   = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [OFF_W-1:0] BYTE_LAST = OFF_W'(BYTE_BITS - 1);

  typedef enum logic [2:0] {
    S_RST_ALL,
    S_IDLE,
    S_EXEC,
    S_MULT_WAIT,
    S_LOAD,
    S_UNLOAD
  } state_t;

  state_t           state;
  logic [OFF_W-1:0] nxt_off;   // offset of the next byte to transfer
  logic [CNT_W-1:0] byte_cnt;  // bytes remaining after the next one
  logic [MC_W-1:0]  mult_cnt;

  logic [SEL_W-1:0] in_dst;
  logic [SEL_W-1:0] in_src;
  logic [3:0]       in_op;

  assign in_dst = instr[INSTR_W-1 -: SEL_W];
  assign in_src = instr[SEL_W+3 : 4];
  assign in_op  = instr[3:0];

  function automatic logic [NUM_BANKS-1:0] onehot(input logic [SEL_W-1:0] s);
    onehot    = '0;
    onehot[s] = 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RST_ALL;
      instr_ready <= 1'b0;
      busy        <= 1'b1;
      src_sel     <= '0;
      dst_sel     <= '0;
      out_sel     <= '0;
      bram_in_sel <= 1'b0;
      wr_en       <= '0;
      wr_en1      <= '0;
      bank_rst    <= '0;
      offset      <= BYTE_LAST;
      done        <= 1'b0;
      err         <= 1'b0;
      nxt_off     <= BYTE_LAST;
      byte_cnt    <= '0;
      mult_cnt    <= '0;
    end else begin
      // enables and status are pulses unless re-asserted below
      wr_en    <= '0;
      wr_en1   <= '0;
      bank_rst <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef MPU_CTRL_ABORT_EN
      if (abort && state != S_IDLE) begin
        state       <= S_IDLE;
        instr_ready <= 1'b1;
        busy        <= 1'b0;
        out_sel     <= '0;
        bram_in_sel <= 1'b0;
        offset      <= BYTE_LAST;
        err         <= 1'b1;
      end else
`endif
      case (state)
        S_RST_ALL: begin
          bank_rst    <= '1;
          state       <= S_IDLE;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end

        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            src_sel  <= in_src;
            dst_sel  <= in_dst;
            offset   <= BYTE_LAST;
            nxt_off  <= BYTE_LAST;
            byte_cnt <= CNT_W'(NBYTES - 1);
            case (in_op)
              4'h0, 4'h1, 4'h2, 4'h3: done <= 1'b1;
              4'h4, 4'h6: begin
                state       <= (in_op == 4'h4) ? S_LOAD : S_UNLOAD;
                instr_ready <= 1'b0;
                busy        <= 1'b1;
              end
              4'h5: begin
                state       <= S_EXEC;
                instr_ready <= 1'b0;
                busy        <= 1'b1;
                bram_in_sel <= 1'b1;
                wr_en       <= onehot(in_dst);
                done        <= 1'b1;
              end
              4'h7: begin
                state       <= S_EXEC;
                instr_ready <= 1'b0;
                busy        <= 1'b1;
                bank_rst    <= onehot(in_dst);
                done        <= 1'b1;
              end
              4'hC, 4'hD, 4'hE: begin
                // op[1:0] maps straight onto the result select encoding
                state       <= S_EXEC;
                instr_ready <= 1'b0;
                busy        <= 1'b1;
                out_sel     <= in_op[1:0];
                wr_en       <= onehot(in_dst);
                done        <= 1'b1;
              end
              4'hF: begin
                state       <= S_MULT_WAIT;
                instr_ready <= 1'b0;
                busy        <= 1'b1;
                out_sel     <= 2'd3;
                mult_cnt    <= MC_W'(MULT_CYCLES - 1);
              end
              default: err <= 1'b1;
            endcase
          end
        end

        S_MULT_WAIT: begin
          if (mult_cnt == '0) begin
            state <= S_EXEC;
            wr_en <= onehot(dst_sel);
            done  <= 1'b1;
          end else begin
            mult_cnt <= mult_cnt - MC_W'(1);
          end
        end

        S_LOAD, S_UNLOAD: begin
          if ((state == S_LOAD) ? host_valid : host_ready) begin
            if (state == S_LOAD) wr_en1 <= onehot(dst_sel);
            offset <= nxt_off;
            if (byte_cnt == '0) begin
              state <= S_EXEC;
              done  <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt - CNT_W'(1);
              nxt_off  <= nxt_off + OFF_W'(BYTE_BITS);
            end
          end
        end

        S_EXEC: begin
          state       <= S_IDLE;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          out_sel     <= '0;
          bram_in_sel <= 1'b0;
          offset      <= BYTE_LAST;
        end

        default: begin
          state       <= S_IDLE;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_ctrl_seq.sv
module tb_mpu_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       host_valid;
  logic       host_ready;
  logic       abort;
  logic [1:0] src_sel, dst_sel, out_sel;
  logic       bram_in_sel;
  logic [3:0] wr_en, wr_en1, bank_rst;
  logic [8:0] offset;
  logic       busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mpu_ctrl_seq dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
`ifdef MPU_CTRL_ABORT_EN
    .abort       (abort),
`endif
    .src_sel     (src_sel),
    .dst_sel     (dst_sel),
    .out_sel     (out_sel),
    .bram_in_sel (bram_in_sel),
    .wr_en       (wr_en),
    .wr_en1      (wr_en1),
    .bank_rst    (bank_rst),
    .offset      (offset),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int wcyc, npulse, nbad, done_off, wr_cnt;
    bit fin;
    logic [3:0] wcap;
    logic dcap, hv;
    logic [8:0] exp_off;

    reset = 1'b1; instr = '0; instr_valid = 1'b0;
    host_valid = 1'b0; host_ready = 1'b0; abort = 1'b0;

    // reset for two cycles
    tick(); tick();
    chk("rst_bank_rst", bank_rst, 4'h0);
    chk("rst_wr_en", wr_en, 4'h0);
    chk("rst_ready", instr_ready, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_offset", offset, 9'd7);
    reset = 1'b0;
    tick();
    chk("rel_bank_rst_all", bank_rst, 4'hF);
    chk("rel_wr_en", wr_en | wr_en1, 4'h0);
    tick();
    chk("idle_bank_rst", bank_rst, 4'h0);
    chk("idle_ready", instr_ready, 1'b1);
    chk("idle_offset", offset, 9'd7);

    // ADD src=1 dst=2
    instr = 8'h9C; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("add_wr_en", wr_en, 4'b0100);
    chk("add_out_sel", out_sel, 2'd0);
    chk("add_done", done, 1'b1);
    chk("add_src_sel", src_sel, 2'd1);
    chk("add_dst_sel", dst_sel, 2'd2);
    chk("add_ready_low", instr_ready, 1'b0);
    tick();
    chk("add_ready_back", instr_ready, 1'b1);
    chk("add_wr_en_clr", wr_en, 4'h0);
    chk("add_done_clr", done, 1'b0);

    // SUB src=3 dst=0
    instr = 8'h3E; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("sub_wr_en", wr_en, 4'b0001);
    chk("sub_out_sel", out_sel, 2'd2);
    tick();

    // MULT dst=3; an ADD to bank 0 offered while busy must be ignored
    instr = 8'hCF; instr_valid = 1'b1;
    tick();
    chk("mult_c1_wr_en", wr_en, 4'h0);
    chk("mult_out_sel", out_sel, 2'd3);
    chk("mult_busy", busy, 1'b1);
    instr = 8'h0C;
    wcyc = 0; wcap = '0; dcap = 1'b0; wr_cnt = 0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (c == 3) instr_valid = 1'b0;
      if (wr_en != 4'h0) begin
        wr_cnt++;
        if (wcyc == 0) begin wcyc = c; wcap = wr_en; dcap = done; end
      end
    end
    chk("mult_latency", wcyc, 5);
    chk("mult_wr_en", wcap, 4'b1000);
    chk("mult_done", dcap, 1'b1);
    chk("mult_single_write", wr_cnt, 1);

    // COPY src=1 dst=1
    instr = 8'h55; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("copy_wr_en", wr_en, 4'b0010);
    chk("copy_in_sel", bram_in_sel, 1'b1);
    chk("copy_done", done, 1'b1);
    tick();
    chk("copy_in_sel_clr", bram_in_sel, 1'b0);

    // CLEAR dst=2
    instr = 8'h87; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("clear_bank_rst", bank_rst, 4'b0100);
    chk("clear_wr_en", wr_en, 4'h0);
    chk("clear_done", done, 1'b1);
    tick();

    // NOP
    instr = 8'h01; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("nop_done", done, 1'b1);
    chk("nop_ready", instr_ready, 1'b1);

    // illegal opcode 0x9
    instr = 8'h09; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("ill_err", err, 1'b1);
    chk("ill_done", done, 1'b0);
    chk("ill_enables", wr_en | wr_en1 | bank_rst, 4'h0);
    chk("ill_ready", instr_ready, 1'b1);
    tick();
    chk("ill_err_clr", err, 1'b0);

    // LOAD dst=0, host_valid low every third cycle
    instr = 8'h04; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("load_start_off", offset, 9'd7);
    chk("load_ready_low", instr_ready, 1'b0);
    npulse = 0; nbad = 0; done_off = -1; fin = 1'b0; exp_off = 9'd7;
    for (int c = 0; c < 300 && !fin; c++) begin
      hv = (c % 3 != 2);
      host_valid = hv;
      tick();
      if (wr_en1 != 4'h0) begin
        npulse++;
        if (!hv || wr_en1 != 4'b0001 || offset != exp_off) nbad++;
        exp_off = exp_off + 9'd8;
        if (npulse == 64) begin
          fin = 1'b1;
          done_off = int'(offset);
          if (!done) nbad++;
        end else if (done) nbad++;
      end else if (hv || done) nbad++;
    end
    host_valid = 1'b0;
    chk("load_pulses", npulse, 64);
    chk("load_bad_steps", nbad, 0);
    chk("load_done_off", done_off, 511);
    tick();
    chk("load_off_return", offset, 9'd7);
    chk("load_ready_back", instr_ready, 1'b1);

    // UNLOAD dst=3, reset after 10 bytes
    instr = 8'hC6; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    host_ready = 1'b1;
    nbad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if ((wr_en | wr_en1 | bank_rst) != 4'h0) nbad++;
    end
    chk("unl_no_enables", nbad, 0);
    chk("unl_offset_b9", offset, 9'd79);
    chk("unl_dst_sel", dst_sel, 2'd3);
    reset = 1'b1;
    tick();
    chk("unl_rst_enables", wr_en | wr_en1 | bank_rst, 4'h0);
    chk("unl_rst_offset", offset, 9'd7);
    chk("unl_rst_done", done, 1'b0);
    tick();
    reset = 1'b0; host_ready = 1'b0;
    tick();
    chk("unl_rel_bank_rst", bank_rst, 4'hF);
    tick();
    chk("unl_idle_ready", instr_ready, 1'b1);
    chk("unl_idle_offset", offset, 9'd7);

`ifdef MPU_CTRL_ABORT_EN
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_ignored", err, 1'b0);
    instr = 8'h44; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    host_valid = 1'b1;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0; host_valid = 1'b0;
    chk("abort_err", err, 1'b1);
    chk("abort_wr_en1", wr_en1, 4'h0);
    chk("abort_done", done, 1'b0);
    chk("abort_ready", instr_ready, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
